// File: rtl/wvb_rd_ctrl_pkg.sv
// Shared types and constants for the waveform buffer readout controller:
// state encoding, header bundle field layout and default widths.
package wvb_rd_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } rd_state_e;

    localparam int ADR_WIDTH  = 15;
    localparam int HDR_WIDTH  = 87;
    localparam int DATA_WIDTH = 22;

    // Header bundle, MSB first: evt_ltc, start_addr, stop_addr, trig_src, cnst_run, pre_conf
    localparam int PRE_CONF_W     = 6;
    localparam int PRE_CONF_LSB   = 0;
    localparam int CNST_RUN_W     = 1;
    localparam int CNST_RUN_LSB   = PRE_CONF_LSB + PRE_CONF_W;
    localparam int TRIG_SRC_W     = 2;
    localparam int TRIG_SRC_LSB   = CNST_RUN_LSB + CNST_RUN_W;
    localparam int STOP_ADDR_W    = 15;
    localparam int STOP_ADDR_LSB  = TRIG_SRC_LSB + TRIG_SRC_W;
    localparam int START_ADDR_W   = 15;
    localparam int START_ADDR_LSB = STOP_ADDR_LSB + STOP_ADDR_W;
    localparam int EVT_LTC_W      = 48;
    localparam int EVT_LTC_LSB    = START_ADDR_LSB + START_ADDR_W;

endpackage

// File: rtl/wvb_rd_ctrl_hdr_fan_out.sv
// Header bundle fan-out: splits the packed waveform buffer header into its fields.
module cuppa_wvb_hdr_bundle_0_fan_out
    import wvb_rd_ctrl_pkg::*;
(
    input  logic [HDR_WIDTH-1:0]    bundle_i,
    output logic [EVT_LTC_W-1:0]    evt_ltc_o,
    output logic [START_ADDR_W-1:0] start_addr_o,
    output logic [STOP_ADDR_W-1:0]  stop_addr_o,
    output logic [TRIG_SRC_W-1:0]   trig_src_o,
    output logic [CNST_RUN_W-1:0]   cnst_run_o,
    output logic [PRE_CONF_W-1:0]   pre_conf_o
);

    assign evt_ltc_o    = bundle_i[EVT_LTC_LSB    +: EVT_LTC_W];
    assign start_addr_o = bundle_i[START_ADDR_LSB +: START_ADDR_W];
    assign stop_addr_o  = bundle_i[STOP_ADDR_LSB  +: STOP_ADDR_W];
    assign trig_src_o   = bundle_i[TRIG_SRC_LSB   +: TRIG_SRC_W];
    assign cnst_run_o   = bundle_i[CNST_RUN_LSB   +: CNST_RUN_W];
    assign pre_conf_o   = bundle_i[PRE_CONF_LSB   +: PRE_CONF_W];

endmodule

// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer readout controller: pops event headers and streams the event's samples.
// Optional event counter output enabled by defining WVB_RD_EVT_CNT_EN.
module wvb_rd_ctrl
    import wvb_rd_ctrl_pkg::*;
#(
    parameter int P_ADR_WIDTH  = ADR_WIDTH,
    parameter int P_HDR_WIDTH  = HDR_WIDTH,
    parameter int P_DATA_WIDTH = DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic                    wvb_rddone,
    output logic [P_DATA_WIDTH-1:0] dout_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_sop,
    output logic                    dout_eop,
`ifdef WVB_RD_EVT_CNT_EN
    output logic [31:0]             evt_cnt,
`endif
    output logic [P_HDR_WIDTH-1:0]  dout_hdr
);

    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;

    rd_state_e               state_q, state_d;
    logic [P_ADR_WIDTH-1:0]  addr_q, addr_d;
    logic [P_ADR_WIDTH-1:0]  stop_q, stop_d;
    logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic                    first_q, first_d;
    logic                    last_issued_q, last_issued_d;
    logic                    inflight_q, inflight_d;
    logic                    infl_sop_q, infl_sop_d;
    logic                    infl_eop_q, infl_eop_d;
    logic [1:0]              count_q, count_d;
    logic                    rdptr_q, rdptr_d;
    logic [P_DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]              buf_sop_q, buf_eop_q;

    logic [P_ADR_WIDTH-1:0]  hdr_start, hdr_stop;
    logic [EVT_LTC_W-1:0]    unused_evt_ltc;
    logic [TRIG_SRC_W-1:0]   unused_trig_src;
    logic [CNST_RUN_W-1:0]   unused_cnst_run;
    logic [PRE_CONF_W-1:0]   unused_pre_conf;

    logic       from_buf, accept, pop, push, issue, issue_eop, wr_idx;
    logic [1:0] occ;

    cuppa_wvb_hdr_bundle_0_fan_out u_hdr_fan_out (
        .bundle_i     (hdr_data),
        .evt_ltc_o    (unused_evt_ltc),
        .start_addr_o (hdr_start),
        .stop_addr_o  (hdr_stop),
        .trig_src_o   (unused_trig_src),
        .cnst_run_o   (unused_cnst_run),
        .pre_conf_o   (unused_pre_conf)
    );

    // The buffer head is shown when occupied, otherwise RAM data is bypassed straight out
    assign from_buf   = (count_q != 2'd0);
    assign dout_valid = from_buf | inflight_q;
    assign dout_data  = from_buf ? buf_data_q[rdptr_q] : (inflight_q ? wvb_rd_data : '0);
    assign dout_sop   = from_buf ? buf_sop_q[rdptr_q] : (inflight_q & infl_sop_q);
    assign dout_eop   = from_buf ? buf_eop_q[rdptr_q] : (inflight_q & infl_eop_q);
    assign accept     = dout_valid & dout_ready;
    assign pop        = accept & from_buf;
    assign push       = inflight_q & ~(accept & ~from_buf);
    assign wr_idx     = rdptr_q ^ count_q[0];

    assign occ        = count_q + {1'b0, inflight_q};
    assign issue      = (state_q == S_READ) && !last_issued_q && (occ < 2'd2);
    assign issue_eop  = (addr_q == stop_q);

    assign wvb_rd_addr = addr_q;
    assign dout_hdr    = hdr_q;
    assign wvb_rddone  = (state_q == S_DONE);
    assign hdr_rdreq   = (state_q == S_DONE);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        stop_d        = stop_q;
        hdr_d         = hdr_q;
        first_d       = first_q;
        last_issued_d = last_issued_q;
        inflight_d    = issue;
        infl_sop_d    = first_q;
        infl_eop_d    = issue_eop;
        rdptr_d       = pop ? ~rdptr_q : rdptr_q;
        count_d       = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        case (state_q)
            S_IDLE: begin
                if (!hdr_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                hdr_d         = hdr_data;
                addr_d        = hdr_start;
                stop_d        = hdr_stop;
                first_d       = 1'b1;
                last_issued_d = 1'b0;
                state_d       = S_READ;
            end
            S_READ: begin
                // Address stays on the last word once issued
                if (issue) begin
                    first_d = 1'b0;
                    if (issue_eop) last_issued_d = 1'b1;
                    else           addr_d = addr_q + ADR_ONE;
                end
                if (accept && dout_eop) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            stop_q        <= '0;
            hdr_q         <= '0;
            first_q       <= 1'b0;
            last_issued_q <= 1'b0;
            inflight_q    <= 1'b0;
            infl_sop_q    <= 1'b0;
            infl_eop_q    <= 1'b0;
            count_q       <= 2'd0;
            rdptr_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            stop_q        <= stop_d;
            hdr_q         <= hdr_d;
            first_q       <= first_d;
            last_issued_q <= last_issued_d;
            inflight_q    <= inflight_d;
            infl_sop_q    <= infl_sop_d;
            infl_eop_q    <= infl_eop_d;
            count_q       <= count_d;
            rdptr_q       <= rdptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_sop_q     <= '0;
            buf_eop_q     <= '0;
        end else if (push) begin
            buf_data_q[wr_idx] <= wvb_rd_data;
            buf_sop_q[wr_idx]  <= infl_sop_q;
            buf_eop_q[wr_idx]  <= infl_eop_q;
        end
    end

`ifdef WVB_RD_EVT_CNT_EN
    logic [31:0] evt_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                    evt_cnt_q <= '0;
        else if (state_q == S_DONE) evt_cnt_q <= evt_cnt_q + 32'd1;
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Directed bench for wvb_rd_ctrl with a registered waveform RAM and a show-ahead header FIFO.
// The event counter checks are compiled in when WVB_RD_EVT_CNT_EN is defined.
module tb_wvb_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [86:0] hdr_data;
    logic        hdr_empty;
    logic        hdr_rdreq;
    logic [14:0] wvb_rd_addr;
    logic [21:0] wvb_rd_data = '0;
    logic        wvb_rddone;
    logic [21:0] dout_data;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_sop;
    logic        dout_eop;
    logic [86:0] dout_hdr;
`ifdef WVB_RD_EVT_CNT_EN
    logic [31:0] evt_cnt;
`endif

    int nVec = 0;
    int nMis = 0;

    logic [86:0] hdrQ[$];
    int          obsCycle[$];
    logic [21:0] obsData[$];
    bit          obsSop[$];
    bit          obsEop[$];
    logic [86:0] obsHdr[$];
    int          doneCycles[$];
    int          rdreqCycles[$];
    int          stallViol;
    int          preRstCount;
    bit          validAfterRst;
    bit          timedOut;

    wvb_rd_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .hdr_data    (hdr_data),
        .hdr_empty   (hdr_empty),
        .hdr_rdreq   (hdr_rdreq),
        .wvb_rd_addr (wvb_rd_addr),
        .wvb_rd_data (wvb_rd_data),
        .wvb_rddone  (wvb_rddone),
        .dout_data   (dout_data),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
`ifdef WVB_RD_EVT_CNT_EN
        .evt_cnt     (evt_cnt),
`endif
        .dout_hdr    (dout_hdr)
    );

    always #5 clk = ~clk;

    // Waveform RAM contents are a fixed function of the address
    function automatic logic [21:0] ramData(input logic [14:0] a);
        return {a[6:0] ^ 7'h55, a};
    endfunction

    always @(posedge clk) wvb_rd_data <= ramData(wvb_rd_addr);

    function automatic logic [86:0] mkHdr(input logic [14:0] s, input logic [14:0] e, input logic [47:0] ltc);
        return {ltc, s, e, 2'b01, 1'b0, 6'h2A};
    endfunction

    // Drives the FIFO and the stream sink cycle by cycle; cycle 0 is the first with hdr_empty low
    task automatic runEngine(input int maxCycles, input bit randReady, input int rstAfter);
        int nEvents, doneSeen, tail, accCount;
        bit popPending, prevValid, prevReady, prevRst, checkAfterRst;
        logic [21:0] prevData;
        bit prevSop, prevEop;
        obsCycle.delete(); obsData.delete(); obsSop.delete(); obsEop.delete(); obsHdr.delete();
        doneCycles.delete(); rdreqCycles.delete();
        nEvents = hdrQ.size(); doneSeen = 0; tail = 0; accCount = 0;
        popPending = 0; prevValid = 0; prevReady = 0; prevRst = 0; checkAfterRst = 0;
        prevData = '0; prevSop = 0; prevEop = 0;
        stallViol = 0; preRstCount = -1; validAfterRst = 0; timedOut = 0;
        for (int c = 0; ; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            rst = 1'b0;
            if (checkAfterRst) begin
                validAfterRst = dout_valid;
                checkAfterRst = 0;
            end
            if (popPending) begin
                void'(hdrQ.pop_front());
                popPending = 0;
            end
            hdr_empty = (hdrQ.size() == 0);
            hdr_data  = hdr_empty ? '0 : hdrQ[0];
            if (hdr_rdreq) begin
                rdreqCycles.push_back(c);
                popPending = 1;
            end
            if (wvb_rddone) begin
                doneCycles.push_back(c);
                doneSeen++;
            end
            if (prevValid && !prevReady && !prevRst) begin
                if (!dout_valid || dout_data !== prevData || dout_sop !== prevSop || dout_eop !== prevEop)
                    stallViol++;
            end
            prevRst = 0;
            if (rstAfter >= 0 && preRstCount < 0 && accCount == rstAfter) begin
                rst = 1'b1;
                dout_ready = 1'b0;
                preRstCount = accCount;
                checkAfterRst = 1;
                prevRst = 1;
                obsCycle.delete(); obsData.delete(); obsSop.delete(); obsEop.delete(); obsHdr.delete();
            end else begin
                dout_ready = randReady ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (dout_valid && dout_ready) begin
                    obsCycle.push_back(c);
                    obsData.push_back(dout_data);
                    obsSop.push_back(dout_sop);
                    obsEop.push_back(dout_eop);
                    obsHdr.push_back(dout_hdr);
                    accCount++;
                end
            end
            prevValid = dout_valid;
            prevReady = dout_ready;
            prevData  = dout_data;
            prevSop   = dout_sop;
            prevEop   = dout_eop;
            if (doneSeen == nEvents) tail++;
            if (tail > 2) break;
            if (c >= maxCycles) begin
                timedOut = 1;
                break;
            end
        end
        dout_ready = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; hdr_empty = 1'b1; hdr_data = '0; dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nVec++; if (dout_valid !== 1'b0) begin nMis++; $display("[TB] FAIL reset_valid: got %b expected 0", dout_valid); end
        nVec++; if (hdr_rdreq !== 1'b0) begin nMis++; $display("[TB] FAIL reset_rdreq: got %b expected 0", hdr_rdreq); end
        nVec++; if (wvb_rddone !== 1'b0) begin nMis++; $display("[TB] FAIL reset_rddone: got %b expected 0", wvb_rddone); end
        nVec++; if (dout_sop !== 1'b0 || dout_eop !== 1'b0) begin nMis++; $display("[TB] FAIL reset_sop_eop: got %b%b expected 00", dout_sop, dout_eop); end
        nVec++; if (wvb_rd_addr !== 15'd0) begin nMis++; $display("[TB] FAIL reset_addr: got %h expected 0", wvb_rd_addr); end
        nVec++; if (dout_data !== 22'd0) begin nMis++; $display("[TB] FAIL reset_data: got %h expected 0", dout_data); end
        nVec++; if (dout_hdr !== 87'd0) begin nMis++; $display("[TB] FAIL reset_hdr: got %h expected 0", dout_hdr); end
`ifdef WVB_RD_EVT_CNT_EN
        nVec++; if (evt_cnt !== 32'd0) begin nMis++; $display("[TB] FAIL reset_evt_cnt: got %0d expected 0", evt_cnt); end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_event;
        logic [86:0] h;
        logic [14:0] a;
        h = mkHdr(15'h0010, 15'h0013, 48'h0000_1234_5678);
        hdrQ.push_back(h);
        runEngine(200, 1'b0, -1);
        nVec++; if (timedOut) begin nMis++; $display("[TB] FAIL single_timeout: got timeout expected completion"); end
        nVec++; if (obsData.size() != 4) begin nMis++; $display("[TB] FAIL single_count: got %0d expected 4", obsData.size()); end
        for (int i = 0; i < obsData.size(); i++) begin
            a = 15'h0010 + 15'(i);
            nVec++; if (obsData[i] !== ramData(a)) begin nMis++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, obsData[i], ramData(a)); end
            nVec++; if (obsCycle[i] != 3 + i) begin nMis++; $display("[TB] FAIL single_cycle[%0d]: got %0d expected %0d", i, obsCycle[i], 3 + i); end
            nVec++; if (obsSop[i] !== (i == 0) || obsEop[i] !== (i == 3)) begin nMis++; $display("[TB] FAIL single_sop_eop[%0d]: got %b%b expected %b%b", i, obsSop[i], obsEop[i], i == 0, i == 3); end
            nVec++; if (obsHdr[i] !== h) begin nMis++; $display("[TB] FAIL single_hdr[%0d]: got %h expected %h", i, obsHdr[i], h); end
        end
        nVec++;
        if (doneCycles.size() != 1) begin nMis++; $display("[TB] FAIL single_done_count: got %0d expected 1", doneCycles.size()); end
        else if (doneCycles[0] != 7) begin nMis++; $display("[TB] FAIL single_done_cycle: got %0d expected 7", doneCycles[0]); end
        nVec++;
        if (rdreqCycles.size() != 1) begin nMis++; $display("[TB] FAIL single_rdreq_count: got %0d expected 1", rdreqCycles.size()); end
        else if (rdreqCycles[0] != 7) begin nMis++; $display("[TB] FAIL single_rdreq_cycle: got %0d expected 7", rdreqCycles[0]); end
    endtask

    task automatic test_wrap;
        logic [14:0] expAddr [4];
        expAddr[0] = 15'h7FFE; expAddr[1] = 15'h7FFF; expAddr[2] = 15'h0000; expAddr[3] = 15'h0001;
        hdrQ.push_back(mkHdr(15'h7FFE, 15'h0001, 48'h1));
        runEngine(200, 1'b0, -1);
        nVec++; if (obsData.size() != 4 || timedOut) begin nMis++; $display("[TB] FAIL wrap_count: got %0d expected 4 (timeout=%0b)", obsData.size(), timedOut); end
        for (int i = 0; i < obsData.size() && i < 4; i++) begin
            nVec++; if (obsData[i] !== ramData(expAddr[i])) begin nMis++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, obsData[i], ramData(expAddr[i])); end
        end
        nVec++; if (doneCycles.size() != 1) begin nMis++; $display("[TB] FAIL wrap_done_count: got %0d expected 1", doneCycles.size()); end
    endtask

    task automatic test_single_sample;
        hdrQ.push_back(mkHdr(15'h0100, 15'h0100, 48'h2));
        runEngine(200, 1'b0, -1);
        nVec++; if (obsData.size() != 1 || timedOut) begin nMis++; $display("[TB] FAIL one_count: got %0d expected 1 (timeout=%0b)", obsData.size(), timedOut); end
        if (obsData.size() == 1) begin
            nVec++; if (obsData[0] !== ramData(15'h0100)) begin nMis++; $display("[TB] FAIL one_data: got %h expected %h", obsData[0], ramData(15'h0100)); end
            nVec++; if (obsSop[0] !== 1'b1 || obsEop[0] !== 1'b1) begin nMis++; $display("[TB] FAIL one_sop_eop: got %b%b expected 11", obsSop[0], obsEop[0]); end
        end
        nVec++;
        if (doneCycles.size() != 1) begin nMis++; $display("[TB] FAIL one_done_count: got %0d expected 1", doneCycles.size()); end
        else if (doneCycles[0] != 4) begin nMis++; $display("[TB] FAIL one_done_cycle: got %0d expected 4", doneCycles[0]); end
    endtask

    task automatic test_random_ready;
        int bad;
        hdrQ.push_back(mkHdr(15'h0200, 15'h023F, 48'h3));
        runEngine(2000, 1'b1, -1);
        nVec++; if (obsData.size() != 64 || timedOut) begin nMis++; $display("[TB] FAIL rand_count: got %0d expected 64 (timeout=%0b)", obsData.size(), timedOut); end
        bad = 0;
        for (int i = 0; i < obsData.size(); i++) begin
            if (obsData[i] !== ramData(15'h0200 + 15'(i)) || obsSop[i] !== (i == 0) || obsEop[i] !== (i == 63)) bad++;
        end
        nVec++; if (bad != 0) begin nMis++; $display("[TB] FAIL rand_order: got %0d bad samples expected 0", bad); end
        nVec++; if (stallViol != 0) begin nMis++; $display("[TB] FAIL rand_stall_stable: got %0d changes expected 0", stallViol); end
        nVec++; if (doneCycles.size() != 1) begin nMis++; $display("[TB] FAIL rand_done_count: got %0d expected 1", doneCycles.size()); end
    endtask

    task automatic test_reset_mid_event;
        int bad;
        hdrQ.push_back(mkHdr(15'h0300, 15'h0313, 48'h4));
        runEngine(400, 1'b0, 5);
        nVec++; if (preRstCount != 5) begin nMis++; $display("[TB] FAIL rst_pre_count: got %0d expected 5", preRstCount); end
        nVec++; if (validAfterRst !== 1'b0) begin nMis++; $display("[TB] FAIL rst_valid_after: got %b expected 0", validAfterRst); end
        nVec++; if (obsData.size() != 20 || timedOut) begin nMis++; $display("[TB] FAIL rst_replay_count: got %0d expected 20 (timeout=%0b)", obsData.size(), timedOut); end
        bad = 0;
        for (int i = 0; i < obsData.size(); i++)
            if (obsData[i] !== ramData(15'h0300 + 15'(i)) || obsSop[i] !== (i == 0)) bad++;
        nVec++; if (bad != 0) begin nMis++; $display("[TB] FAIL rst_replay_data: got %0d bad samples expected 0", bad); end
        nVec++; if (doneCycles.size() != 1 || rdreqCycles.size() != 1) begin nMis++; $display("[TB] FAIL rst_done_count: got %0d/%0d expected 1/1", doneCycles.size(), rdreqCycles.size()); end
    endtask

    task automatic test_back_to_back;
        logic [14:0] expAddr [9];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expAddr[0] = 15'h0400; expAddr[1] = 15'h0401; expAddr[2] = 15'h0402;
        expAddr[3] = 15'h0410; expAddr[4] = 15'h0411; expAddr[5] = 15'h0412; expAddr[6] = 15'h0413;
        expAddr[7] = 15'h7FFF; expAddr[8] = 15'h0000;
        hdrQ.push_back(mkHdr(15'h0400, 15'h0402, 48'hA));
        hdrQ.push_back(mkHdr(15'h0410, 15'h0413, 48'hB));
        hdrQ.push_back(mkHdr(15'h7FFF, 15'h0000, 48'hC));
        runEngine(400, 1'b0, -1);
        nVec++; if (obsData.size() != 9 || timedOut) begin nMis++; $display("[TB] FAIL b2b_count: got %0d expected 9 (timeout=%0b)", obsData.size(), timedOut); end
        if (obsData.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                nVec++; if (obsData[i] !== ramData(expAddr[i])) begin nMis++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, obsData[i], ramData(expAddr[i])); end
            end
            nVec++; if (obsCycle[3] - obsCycle[2] != 5) begin nMis++; $display("[TB] FAIL b2b_gap_ab: got %0d expected 5", obsCycle[3] - obsCycle[2]); end
            nVec++; if (obsCycle[7] - obsCycle[6] != 5) begin nMis++; $display("[TB] FAIL b2b_gap_bc: got %0d expected 5", obsCycle[7] - obsCycle[6]); end
            nVec++; if (!obsSop[3] || !obsSop[7] || !obsEop[2] || !obsEop[6] || !obsEop[8]) begin nMis++; $display("[TB] FAIL b2b_framing: got sop3=%b sop7=%b eop2=%b eop6=%b eop8=%b expected all 1", obsSop[3], obsSop[7], obsEop[2], obsEop[6], obsEop[8]); end
        end
        nVec++; if (doneCycles.size() != 3) begin nMis++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneCycles.size()); end
`ifdef WVB_RD_EVT_CNT_EN
        nVec++; if (evt_cnt !== 32'd3) begin nMis++; $display("[TB] FAIL b2b_evt_cnt: got %0d expected 3", evt_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_wrap();
        test_single_sample();
        test_random_ready();
        test_reset_mid_event();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
